// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage for the MIPS pipeline.
// Owns the fetch PC, issues one-at-a-time requests to instruction memory,
// buffers returned words in a small in-order queue and presents the head
// entry to decode with a valid/ready handshake. Redirects flush everything.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   imem_req/imem_addr             request and word address to instruction memory
//   imem_ack/imem_rdata            completion and instruction word from memory
//   redirect_valid/redirect_pc     taken branch/jump: flush and restart fetch
//   id_ready                       decode accepts the head instruction
//   id_valid/id_instr/id_pc/id_pc4 head-of-queue instruction to decode
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t           queue_q [DEPTH];
    entry_t           queue_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;   // always word aligned
    logic             push;
    logic             pop;
    logic             not_empty;
    entry_t           head;

    // Request/handshake decode; a redirect cancels both the push and the pop.
    assign not_empty = (count_q != '0);
    assign imem_req  = !rst && (count_q < CNT_W'(DEPTH));
    assign imem_addr = fetch_pc_q;
    assign id_valid  = !rst && not_empty;
    assign push      = imem_req && imem_ack && !redirect_valid;
    assign pop       = id_valid && id_ready && !redirect_valid;

    // Head entry; forced to zero while empty so decode never sees stale data.
    assign head     = queue_q[rd_ptr_q];
    assign id_instr = not_empty ? head.instr : '0;
    assign id_pc    = not_empty ? head.pc : '0;
    assign id_pc4   = not_empty ? (head.pc + 32'd4) : '0;

    // Next-state: redirect flushes, otherwise push/pop update pointers and count.
    always_comb begin
        queue_d    = queue_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        fetch_pc_d = fetch_pc_q;

        if (redirect_valid) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end else begin
            if (push) begin
                queue_d[wr_ptr_q].pc    = fetch_pc_q;
                queue_d[wr_ptr_q].instr = imem_rdata;
                wr_ptr_d                = wr_ptr_q + PTR_W'(1);
                fetch_pc_d              = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                queue_q[i] <= '0;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            fetch_pc_q <= RESET_PC_ALIGNED;
        end else begin
            queue_q    <= queue_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 54-instruction MIPS pipeline.
- Owns the fetch PC and issues requests to instruction memory.
- Buffers returned instructions in a small in-order queue and hands them to the IF/ID boundary with a valid/ready handshake.
- Accepts branch/jump redirects from later stages and squashes wrong-path fetches.

Parameters:
- RESET_PC, 32'h00400000, fetch PC loaded on reset.
- DEPTH, 2, fetch queue entries; power of two, minimum 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  word address of request; equals fetch_pc.
- imem_ack  input  1  memory returns data this cycle; valid only while imem_req=1.
- imem_rdata  input  32  instruction word; valid when imem_ack=1.
- redirect_valid  input  1  branch/jump taken; flush and restart.
- redirect_pc  input  32  new fetch target.
- id_ready  input  1  decode can accept an instruction this cycle (0 = stall).
- id_valid  output  1  id_instr/id_pc hold a valid instruction.
- id_instr  output  32  instruction at queue head.
- id_pc  output  32  PC of id_instr.
- id_pc4  output  32  id_pc+4 (mod 2^32), for link/branch-offset use.

Behaviour:
- State: fetch_pc (32b), queue of DEPTH entries {pc, instr}, read/write pointers, count (0..DEPTH).
- Reset (rst=1 at clock edge):
  - fetch_pc <= RESET_PC; count <= 0; pointers <= 0.
  - imem_req=0 and id_valid=0 during any cycle with rst=1.
  - id_instr/id_pc/id_pc4 read 0 while empty after reset.
  - Reset mid-stream discards queue contents and any in-flight ack.
- Request generation (combinational):
  - imem_req = !rst && (count < DEPTH).
  - imem_addr = {fetch_pc[31:2], 2'b00}.
  - Memory may hold ack low indefinitely; imem_addr stays stable until ack or redirect.
  - At most one request is outstanding; memory completes it on any cycle with imem_req&imem_ack (same-cycle allowed).
- Fetch accept (imem_req & imem_ack & !redirect_valid):
  - Push {fetch_pc, imem_rdata} into the queue.
  - fetch_pc <= fetch_pc + 4; wraps 0xFFFFFFFC -> 0x00000000.
- Dequeue (id_valid & id_ready & !redirect_valid):
  - Pop the head entry.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Full queue never receives a push, because imem_req=0 when full.
  - A pop while full re-enables imem_req on the next cycle, not the same cycle.
- Outputs:
  - id_valid = (count != 0) && !rst.
  - id_instr and id_pc are read combinationally from the head entry.
  - id_pc4 = id_pc + 4.
  - Latency: ack at cycle N -> id_valid=1 with that instruction at cycle N+1.
  - Throughput: 1 instruction/cycle with ack every cycle and id_ready=1.
- Redirect (redirect_valid=1) has highest priority after rst:
  - Queue flushed: count <= 0, pointers reset.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}; low two bits ignored.
  - Any imem_ack in the same cycle is discarded.
  - Any pop in the same cycle does not happen; decode treats id_valid as squashed.
  - Next cycle: id_valid=0, imem_req=1, imem_addr=redirect target.
  - Back-to-back redirects: the last one wins.
- No other state; no X on outputs after the first reset edge.

Test Plan:
- Reset, then deassert; imem_ack=0 -> imem_req=1, imem_addr=0x00400000, id_valid=0, held stable over 5 cycles.
- imem_ack=1 and id_ready=1 every cycle, rdata=0x20080000+i -> id_pc sequence 0x00400000, 0x00400004, 0x00400008 starting one cycle after the first ack, one per cycle; id_pc4 = id_pc+4.
- id_ready=0 with ack always 1 -> after 2 pushes imem_req=0 and imem_addr=0x00400008; raise id_ready -> entries drain in order 0x00400000, 0x00400004, and imem_req reasserts the cycle after the first pop.
- Queue full, redirect_valid=1 with redirect_pc=0x00400103 and imem_ack=1 in the same cycle -> next cycle id_valid=0, imem_addr=0x00400100; first delivered id_pc=0x00400100 and no stale instruction appears.
- Redirect to 0xFFFFFFFC, ack twice -> id_pc=0xFFFFFFFC (id_pc4=0x00000000), then id_pc=0x00000000.
- rst pulsed for one cycle with queue full and a pending request -> the following cycle id_valid=0, imem_addr=0x00400000, count=0.
